dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store master that drives the byte-addressed data memory on behalf of the core. Accepts one load or store at a time over a valid/ready handshake and decodes RISC-V funct3 size and sign. Performs read-modify-write for byte and halfword stores, because the memory always writes four bytes at Addr. Returns sign- or zero-extended load data, or an error flag, on a one-cycle response strobe.

## Interface
- ADDR_LIMIT, 1024: memory size in bytes; legal accesses satisfy ReqAddr <= ADDR_LIMIT-4.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept; high only in IDLE.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqFunct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- ReqAddr  in  32  byte address.
- ReqWData  in  32  store data; the low bits are used for B/H.
- RespValid  out  1  one-cycle completion strobe.
- RespRData  out  32  load result; 0 for stores and errors.
- RespErr  out  1  request rejected; valid with RespValid.
- Addr  out  32  memory byte address.
- DataW  out  32  memory write data.
- MemRW  out  1  memory write enable; memory writes at the rising edge.
- DataR  in  32  memory combinational read data, little-endian from Addr.

## Operation
- States: IDLE, READ, WRITE, RESP. State register and all capture registers reset to IDLE/0.
- IDLE behaviour:
  - ReqReady=1.
  - On ReqValid, capture addr, funct3, wdata and write; then check the request.
  - Error cases go to RESP with err=1:
    - misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0;
    - ReqAddr > ADDR_LIMIT-4;
    - funct3 in {011,110,111};
    - ReqWrite=1 with funct3 100 or 101.
  - Otherwise go to READ.
- READ: Addr=captured addr; register DataR into rdata_q. A load goes to RESP. A store goes to WRITE.
- WRITE:
  - DataW merge:
    - B: {rdata_q[31:8], wdata[7:0]};
    - H: {rdata_q[31:16], wdata[15:0]};
    - W: wdata.
  - MemRW=1; go to RESP.
- RESP:
  - RespValid=1 and RespErr=err.
  - Load data:
    - B: sign-extend rdata_q[7:0];
    - BU: zero-extend rdata_q[7:0];
    - H: sign-extend rdata_q[15:0];
    - HU: zero-extend rdata_q[15:0];
    - W: rdata_q.
  - Go to IDLE.
- Outside their active states, outputs hold fixed values:
  - Addr = captured addr in READ/WRITE, 0 in IDLE/RESP;
  - DataW = 0 outside WRITE;
  - RespRData = 0 outside RESP.
- Memory protection:
  - MemRW = (state==WRITE) && rst_n. Reset asserted during WRITE therefore suppresses the write.
  - An erroring request never asserts MemRW.

## Timing
- Reset values: ReqReady=1 after the reset edge, RespValid=0, RespErr=0, RespRData=0, MemRW=0, Addr=0, DataW=0.
- Acceptance occurs at the edge where ReqValid && ReqReady. No request is accepted again until the block returns to IDLE, so the minimum spacing between accepts is load 3, store 4, error 2 cycles.
- Load: READ is the cycle after accept; RespValid is high 2 cycles after accept.
- Store: READ, then WRITE; memory updates at the edge ending WRITE; RespValid is high 3 cycles after accept.
- Error: RespValid is high 1 cycle after accept.
- RespValid is exactly one cycle wide. There is no response backpressure.
- ReqValid while not in IDLE is ignored; the requester must hold the request until ReqReady.
- Request inputs are sampled only at acceptance; later changes have no effect.
- Reset mid-operation: the next edge returns the block to IDLE with no response issued.

## Test plan
- Memory bytes 40..43 = 0A 00 00 00; LW at 40 -> RespValid 2 cycles after accept, RespRData=0x0000000A, RespErr=0, MemRW never high.
- SB 0xAB at 41 over that word -> MemRW high for one cycle with Addr=41, DataW=0x000000AB (bytes 42..44 preserved); a following LW at 40 returns 0x0000AB0A.
- Byte at 44 = 0x80: LB -> 0xFFFFFF80, LBU -> 0x00000080. Halfword 0x8001 at 44: LH -> 0xFFFF8001, LHU -> 0x00008001.
- Error cases -> RespErr=1 one cycle after accept, RespRData=0, MemRW never high:
  - LW at 42;
  - SH at 43;
  - SW at 1021;
  - funct3=011;
  - store with funct3=100.
- SW 0x12345678 at 48 with rst_n dropped in the WRITE cycle -> MemRW low, memory at 48 unchanged, no RespValid, ReqReady=1 after reset.
- Back-to-back handling:
  - Hold ReqValid high across a store -> the second request is accepted only on the cycle after RespValid.
  - A ReqValid pulse during READ is ignored.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store master for a byte-addressed data memory: one request at a time,
// read-modify-write for sub-word stores, sign/zero-extended load responses.
module dmem_lsu #(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [2:0]  ReqFunct3,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    output logic [31:0] RespRData,
    output logic        RespErr,
    output logic [31:0] Addr,
    output logic [31:0] DataW,
    output logic        MemRW,
    input  logic [31:0] DataR
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] MAX_ADDR = XLEN'(ADDR_LIMIT - 4);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              write_q, write_d;
    logic              err_q, err_d;

    logic              req_err_c;
    logic              misalign_c;
    logic              bad_f3_c;
    logic [XLEN-1:0]   load_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            err_q    <= err_d;
        end
    end

    // Request legality, evaluated on the live request inputs at acceptance.
    always_comb begin
        misalign_c = ((ReqFunct3[1:0] == 2'b01) && ReqAddr[0])
                  || ((ReqFunct3 == F3_W) && (ReqAddr[1:0] != 2'b00));
        bad_f3_c   = (ReqFunct3 == 3'b011) || (ReqFunct3 == 3'b110) || (ReqFunct3 == 3'b111);
        req_err_c  = misalign_c || bad_f3_c || (ReqAddr > MAX_ADDR)
                  || (ReqWrite && ReqFunct3[2]);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (ReqValid) begin
                    addr_d   = ReqAddr;
                    wdata_d  = ReqWData;
                    funct3_d = ReqFunct3;
                    write_d  = ReqWrite;
                    err_d    = req_err_c;
                    state_d  = req_err_c ? S_RESP : S_READ;
                end
            end
            S_READ: begin
                rdata_d = DataR;
                state_d = write_q ? S_WRITE : S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_c = '0;
        case (funct3_q)
            F3_B:    load_c = {{24{rdata_q[7]}}, rdata_q[7:0]};
            F3_BU:   load_c = {24'h000000, rdata_q[7:0]};
            F3_H:    load_c = {{16{rdata_q[15]}}, rdata_q[15:0]};
            F3_HU:   load_c = {16'h0000, rdata_q[15:0]};
            F3_W:    load_c = rdata_q;
            default: load_c = '0;
        endcase
    end

    // Outputs decode from state; stale rdata_q is masked for stores and errors.
    always_comb begin
        ReqReady  = (state_q == S_IDLE);
        RespValid = 1'b0;
        RespErr   = 1'b0;
        RespRData = '0;
        Addr      = '0;
        DataW     = '0;
        MemRW     = 1'b0;
        case (state_q)
            S_READ: Addr = addr_q;
            S_WRITE: begin
                Addr  = addr_q;
                MemRW = rst_n;
                case (funct3_q)
                    F3_B:    DataW = {rdata_q[31:8], wdata_q[7:0]};
                    F3_H:    DataW = {rdata_q[31:16], wdata_q[15:0]};
                    default: DataW = wdata_q;
                endcase
            end
            S_RESP: begin
                RespValid = 1'b1;
                RespErr   = err_q;
                if (!err_q && !write_q) begin
                    RespRData = load_c;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed vector bench for dmem_lsu with a byte-array memory model.
module tb_dmem_lsu;

    localparam int unsigned ADDR_LIMIT = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [2:0]  ReqFunct3;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic [31:0] RespRData;
    logic        RespErr;
    logic [31:0] Addr;
    logic [31:0] DataW;
    logic        MemRW;
    logic [31:0] DataR;

    logic [7:0]  mem [0:ADDR_LIMIT-1];
    logic        init_mem;

    int n_tests = 0;
    int n_fail  = 0;
    int memrw_cnt = 0;
    int resp_cnt  = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_dataw = '0;

    dmem_lsu #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqWrite  (ReqWrite),
        .ReqFunct3 (ReqFunct3),
        .ReqAddr   (ReqAddr),
        .ReqWData  (ReqWData),
        .RespValid (RespValid),
        .RespRData (RespRData),
        .RespErr   (RespErr),
        .Addr      (Addr),
        .DataW     (DataW),
        .MemRW     (MemRW),
        .DataR     (DataR)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mb(input logic [31:0] a);
        if (a < 32'(ADDR_LIMIT)) return mem[a[9:0]];
        return 8'h00;
    endfunction

    always_comb DataR = {mb(Addr + 32'd3), mb(Addr + 32'd2), mb(Addr + 32'd1), mb(Addr)};

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < int'(ADDR_LIMIT); i++) mem[i] <= 8'h00;
            mem[40] <= 8'h0A;
            mem[48] <= 8'h11;
            mem[49] <= 8'h22;
            mem[50] <= 8'h33;
            mem[51] <= 8'h44;
        end else if (MemRW) begin
            for (int i = 0; i < 4; i++) begin
                if (Addr + 32'(i) < 32'(ADDR_LIMIT)) mem[Addr + 32'(i)] <= DataW[8*i +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (MemRW) begin
            memrw_cnt++;
            last_waddr = Addr;
            last_dataw = DataW;
        end
        if (RespValid) resp_cnt++;
    end

    typedef struct {
        string       name;
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          memrw;
        logic [31:0] dataw;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] rd,
                       input logic er, input int mrw, input logic [31:0] dw);
        vec_t v;
        v.name = name; v.write = w; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.lat = lat; v.rdata = rd; v.err = er; v.memrw = mrw; v.dataw = dw;
        vecs.push_back(v);
    endtask

    // Present a request and wait (bounded) until ReqReady is seen; returns at posedge+1 after accept.
    task automatic present(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic ok);
        ReqWrite = w; ReqFunct3 = f3; ReqAddr = a; ReqWData = wd; ReqValid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = ReqReady;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        ReqValid = 1'b0; ReqWrite = ~ReqWrite; ReqFunct3 = 3'b111;
        ReqAddr = 32'hFFFF_FFFF; ReqWData = 32'hA5A5_A5A5;
    endtask

    task automatic run_vec(input vec_t v);
        logic ok;
        logic got;
        int lat;
        int m0;
        logic [31:0] rd;
        logic er;
        m0 = memrw_cnt; got = 1'b0; lat = 0; rd = '0; er = 1'b0;
        present(v.write, v.f3, v.addr, v.wdata, ok);
        chk({v.name, "_accept"}, 32'(ok), 32'd1);
        scramble();
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (RespValid) begin
                got = 1'b1; lat = k; rd = RespRData; er = RespErr;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        chk({v.name, "_latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, "_rdata"}, rd, v.rdata);
        chk({v.name, "_err"}, 32'(er), 32'(v.err));
        chk({v.name, "_memrw_cycles"}, 32'(memrw_cnt - m0), 32'(v.memrw));
        if (v.memrw != 0) begin
            chk({v.name, "_waddr"}, last_waddr, v.addr);
            chk({v.name, "_dataw"}, last_dataw, v.dataw);
        end
    endtask

    initial begin
        logic ok;
        logic [9:0] rdy_v;
        logic [9:0] rsp_v;
        int m0;
        int r0;

        // name, write, f3, addr, wdata, latency, rdata, err, memrw cycles, dataw
        add("lw40",     1'b0, 3'b010, 32'd40,   32'h0,           2, 32'h0000_000A, 1'b0, 0, 32'h0);
        add("sb41",     1'b1, 3'b000, 32'd41,   32'hFFFF_FFAB,   3, 32'h0,         1'b0, 1, 32'h0000_00AB);
        add("lw40b",    1'b0, 3'b010, 32'd40,   32'h0,           2, 32'h0000_AB0A, 1'b0, 0, 32'h0);
        add("sb44",     1'b1, 3'b000, 32'd44,   32'h0000_0080,   3, 32'h0,         1'b0, 1, 32'h0000_0080);
        add("lb44",     1'b0, 3'b000, 32'd44,   32'h0,           2, 32'hFFFF_FF80, 1'b0, 0, 32'h0);
        add("lbu44",    1'b0, 3'b100, 32'd44,   32'h0,           2, 32'h0000_0080, 1'b0, 0, 32'h0);
        add("sh44",     1'b1, 3'b001, 32'd44,   32'h1234_8001,   3, 32'h0,         1'b0, 1, 32'h0000_8001);
        add("lh44",     1'b0, 3'b001, 32'd44,   32'h0,           2, 32'hFFFF_8001, 1'b0, 0, 32'h0);
        add("lhu44",    1'b0, 3'b101, 32'd44,   32'h0,           2, 32'h0000_8001, 1'b0, 0, 32'h0);
        add("lb45",     1'b0, 3'b000, 32'd45,   32'h0,           2, 32'hFFFF_FF80, 1'b0, 0, 32'h0);
        add("sw1020",   1'b1, 3'b010, 32'd1020, 32'hDEAD_BEEF,   3, 32'h0,         1'b0, 1, 32'hDEAD_BEEF);
        add("lw1020",   1'b0, 3'b010, 32'd1020, 32'h0,           2, 32'hDEAD_BEEF, 1'b0, 0, 32'h0);
        add("e_lw42",   1'b0, 3'b010, 32'd42,   32'h0,           1, 32'h0,         1'b1, 0, 32'h0);
        add("e_sh43",   1'b1, 3'b001, 32'd43,   32'h1111_2222,   1, 32'h0,         1'b1, 0, 32'h0);
        add("e_sw1021", 1'b1, 3'b010, 32'd1021, 32'h3333_4444,   1, 32'h0,         1'b1, 0, 32'h0);
        add("e_f3_011", 1'b0, 3'b011, 32'd40,   32'h0,           1, 32'h0,         1'b1, 0, 32'h0);
        add("e_st_100", 1'b1, 3'b100, 32'd40,   32'h5555_6666,   1, 32'h0,         1'b1, 0, 32'h0);
        add("e_lb1021", 1'b0, 3'b000, 32'd1021, 32'h0,           1, 32'h0,         1'b1, 0, 32'h0);
        add("e_lhu45",  1'b0, 3'b101, 32'd45,   32'h0,           1, 32'h0,         1'b1, 0, 32'h0);
        add("e_f3_110", 1'b0, 3'b110, 32'd40,   32'h0,           1, 32'h0,         1'b1, 0, 32'h0);
        add("e_lw1024", 1'b0, 3'b010, 32'd1024, 32'h0,           1, 32'h0,         1'b1, 0, 32'h0);

        rst_n = 1'b0; init_mem = 1'b1;
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqFunct3 = 3'b000; ReqAddr = '0; ReqWData = '0;
        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ReqReady), 32'd1);
        chk("rst_respvalid", 32'(RespValid), 32'd0);
        chk("rst_resperr", 32'(RespErr), 32'd0);
        chk("rst_rdata", RespRData, 32'h0);
        chk("rst_memrw", 32'(MemRW), 32'd0);
        chk("rst_addr", Addr, 32'h0);
        chk("rst_dataw", DataW, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted during WRITE must suppress the store and any response.
        m0 = memrw_cnt; r0 = resp_cnt;
        present(1'b1, 3'b010, 32'd48, 32'h1234_5678, ok);
        chk("rstw_accept", 32'(ok), 32'd1);
        scramble();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstw_in_write_dataw", DataW, 32'h1234_5678);
        chk("rstw_memrw", 32'(MemRW), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_ready", 32'(ReqReady), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("rstw_no_resp", 32'(resp_cnt - r0), 32'd0);
        chk("rstw_no_write", 32'(memrw_cnt - m0), 32'd0);
        chk("rstw_mem48", {mem[51], mem[50], mem[49], mem[48]}, 32'h4433_2211);

        // ReqValid held high across stores: next accept only after RespValid.
        ReqWrite = 1'b1; ReqFunct3 = 3'b000; ReqAddr = 32'd60; ReqWData = 32'h0000_005A; ReqValid = 1'b1;
        rdy_v = '0; rsp_v = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rdy_v = {rdy_v[8:0], ReqReady};
            rsp_v = {rsp_v[8:0], RespValid};
            @(posedge clk);
            #1;
        end
        ReqValid = 1'b0;
        chk("hold_ready_pattern", 32'(rdy_v), 32'(10'b1000100010));
        chk("hold_resp_pattern", 32'(rsp_v), 32'(10'b0001000100));
        repeat (5) @(posedge clk);
        #1;
        chk("hold_mem60", 32'(mem[60]), 32'h0000_005A);

        // A ReqValid pulse during READ is ignored.
        present(1'b0, 3'b010, 32'd40, 32'h0, ok);
        chk("pulse_accept", 32'(ok), 32'd1);
        ReqFunct3 = 3'b011; ReqAddr = 32'd3; ReqValid = 1'b1;
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        r0 = resp_cnt;
        @(negedge clk);
        chk("pulse_respvalid", 32'(RespValid), 32'd1);
        chk("pulse_rdata", RespRData, 32'h0000_AB0A);
        chk("pulse_err", 32'(RespErr), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("pulse_single_resp", 32'(resp_cnt - r0), 32'd1);
        chk("pulse_idle_ready", 32'(ReqReady), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
